// File: rtl/output_port_demux_pkg.sv
// Shared definitions for the output port demux: IOQ header field positions,
// the header ctrl tag and the packet-steering FSM encoding.
package output_port_demux_pkg;

  // Bit offset of the one-hot destination bitmap inside the IOQ module header word.
  localparam int IOQ_DST_PORT_POS = 0;

  // Ctrl byte tagging the IOQ module header word.
  localparam logic [7:0] IO_QUEUE_STAGE_NUM_DEFAULT = 8'hff;

  typedef enum logic [1:0] {
    ST_SOP  = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } demux_state_e;

  // A non-zero ctrl word only closes a packet once payload (ctrl==0) has been seen;
  // before that it is another module header.
  function automatic logic ends_packet(input logic ctrl_is_zero, input logic in_pkt);
    return !ctrl_is_zero && in_pkt;
  endfunction

endpackage

// File: rtl/output_port_demux_small_fifo.sv
// Small first-word-fall-through FIFO: dout always shows the head word, rd_en pops it.
// Active-high asynchronous reset flushes the pointers; storage is not cleared.
module output_port_demux_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_COUNT   = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NEARLY_COUNT = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      full;
  logic                      do_wr;
  logic                      do_rd;

  assign empty       = (count == '0);
  assign full        = (count == FULL_COUNT);
  assign nearly_full = (count >= NEARLY_COUNT);
  // A write into a full FIFO is discarded rather than corrupting the head.
  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_port_demux.sv
// Output port demux: steers each packet to the output queues named in its IOQ header
// bitmap (unicast or replicated), drops packets without a usable header, counts both.
module output_port_demux
  import output_port_demux_pkg::*;
#(
  parameter int                    DATA_WIDTH         = 64,
  parameter int                    CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int                    NUM_OUTPUT_QUEUES  = 8,
  parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM_DEFAULT),
  parameter int                    FIFO_DEPTH_BITS    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
  input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
  output logic [31:0]                  num_pkts_fwd,
  output logic [31:0]                  num_pkts_drop,
  output demux_state_e                 dbg_state
);

  // Handshake: upstream may assert in_wr only while in_rdy is high (in_rdy is
  // registered-derived, so sampling it before the edge is safe); a queue accepts a
  // word on the cycle its out_wr bit is high, and out_wr is only raised for a word
  // popped while every selected queue showed out_rdy.

  localparam int FIFO_WIDTH = CTRL_WIDTH + DATA_WIDTH;

  demux_state_e                 state;
  demux_state_e                 state_nxt;
  logic [NUM_OUTPUT_QUEUES-1:0] dst_mask;
  logic [NUM_OUTPUT_QUEUES-1:0] dst_mask_nxt;
  logic                         in_pkt;
  logic                         in_pkt_nxt;

  logic [FIFO_WIDTH-1:0]        head_word;
  logic [DATA_WIDTH-1:0]        head_data;
  logic [CTRL_WIDTH-1:0]        head_ctrl;
  logic [NUM_OUTPUT_QUEUES-1:0] head_dst;
  logic                         fifo_empty;
  logic                         fifo_nearly_full;

  logic                         pop;
  logic                         fwd_pop;
  logic                         fwd_inc;
  logic                         drop_inc;

  output_port_demux_small_fifo #(
    .WIDTH          (FIFO_WIDTH),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (!reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr),
    .rd_en       (pop),
    .dout        (head_word),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign head_data = head_word[DATA_WIDTH-1:0];
  assign head_ctrl = head_word[DATA_WIDTH +: CTRL_WIDTH];
  assign head_dst  = head_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
  assign in_rdy    = !fifo_nearly_full;
  assign dbg_state = state;

  always_comb begin
    state_nxt    = state;
    dst_mask_nxt = dst_mask;
    in_pkt_nxt   = in_pkt;
    pop          = 1'b0;
    fwd_pop      = 1'b0;
    fwd_inc      = 1'b0;
    drop_inc     = 1'b0;

    case (state)
      ST_SOP: begin
        // Decide from the peeked head; the header itself is popped later in FWD/DROP.
        if (!fifo_empty) begin
          if (head_ctrl == IO_QUEUE_STAGE_NUM) begin
            dst_mask_nxt = head_dst;
            if (head_dst != '0) begin
              state_nxt = ST_FWD;
            end else begin
              state_nxt = ST_DROP;
              drop_inc  = 1'b1;
            end
          end else begin
            state_nxt = ST_DROP;
            drop_inc  = 1'b1;
          end
        end
      end
      ST_FWD: begin
        // All selected queues advance together or not at all.
        pop     = !fifo_empty && ((out_rdy & dst_mask) == dst_mask);
        fwd_pop = pop;
      end
      ST_DROP: begin
        pop = !fifo_empty;
      end
      default: begin
        state_nxt = ST_SOP;
      end
    endcase

    if (pop) begin
      if (head_ctrl == '0) begin
        in_pkt_nxt = 1'b1;
      end else if (ends_packet(1'b0, in_pkt)) begin
        in_pkt_nxt = 1'b0;
        state_nxt  = ST_SOP;
        fwd_inc    = (state == ST_FWD);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_SOP;
      dst_mask      <= '0;
      in_pkt        <= 1'b0;
      out_wr        <= '0;
      out_data      <= '0;
      out_ctrl      <= '0;
      num_pkts_fwd  <= '0;
      num_pkts_drop <= '0;
    end else begin
      state    <= state_nxt;
      dst_mask <= dst_mask_nxt;
      in_pkt   <= in_pkt_nxt;
      out_wr   <= {NUM_OUTPUT_QUEUES{fwd_pop}} & dst_mask;
      // Shared bus holds the last forwarded word through stalls and drops.
      if (fwd_pop) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
      end
      if (fwd_inc) begin
        num_pkts_fwd <= num_pkts_fwd + 32'd1;
      end
      if (drop_inc) begin
        num_pkts_drop <= num_pkts_drop + 32'd1;
      end
    end
  end

endmodule
